// File: rtl/gpio_input_reader.sv
// Input-side GPIO peripheral: synchronizes and debounces 32 pins,
// latches rising edges, and exposes state/edges/mask/count to loads.
module gpio_input_reader #(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [63:0] BASE_ADDR       = 64'h0500_0000_0000_0010
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        read_valid,
    input  logic [31:0] GPIO1,
    output logic        irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [31:0]   sync0;
    logic [31:0]   sync1;
    logic [31:0]   stable;
    logic [31:0]   stable_nxt;
    logic [31:0]   rise;
    logic [31:0]   edges;
    logic [31:0]   edges_nxt;
    logic [31:0]   mask;
    logic [31:0]   clr;
    logic [CW-1:0] cnt     [32];
    logic [CW-1:0] cnt_nxt [32];
    logic [63:0]   count;
    logic [63:0]   offset;
    logic [63:0]   rdata;
    logic          unused;

    assign unused = ^write_data[63:32];

    // A pin flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 32; i++) begin
            cnt_nxt[i] = '0;
            if (sync1[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = sync1[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        rise = stable_nxt & ~stable;
    end

    always_comb begin
        offset = address - BASE_ADDR;
        rdata  = '0;
        clr    = '0;
        case (offset)
            64'd0:   rdata = {32'b0, stable};
            64'd1:   rdata = {32'b0, edges};
            64'd3:   rdata = {32'b0, mask};
            64'd4:   rdata = count;
            default: rdata = '0;
        endcase
        if (write && offset == 64'd2) begin
            clr = write_data[31:0];
        end
        // A new rising edge overrides a same-cycle clear of that bit.
        edges_nxt = (edges & ~clr) | rise;
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            sync0      <= '0;
            sync1      <= '0;
            stable     <= '0;
            edges      <= '0;
            mask       <= '0;
            count      <= '0;
            irq        <= 1'b0;
            read_valid <= 1'b0;
            read_data  <= '0;
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync0  <= GPIO1;
            sync1  <= sync0;
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
            edges  <= edges_nxt;
            if (|rise) begin
                count <= count + 64'd1;
            end
            if (write && offset == 64'd3) begin
                mask <= write_data[31:0];
            end
            irq        <= |(edges & mask);
            read_valid <= read;
            if (read) begin
                read_data <= rdata;
            end
        end
    end

endmodule
